// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS instruction-fetch stage: PC, next-PC select, IF/ID register, trap entry
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exception,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] epc,
    output logic        epc_we
);

    localparam logic [1:0] SRC_SEQ    = 2'd0;
    localparam logic [1:0] SRC_BRANCH = 2'd1;
    localparam logic [1:0] SRC_JUMP   = 2'd2;
    localparam logic [1:0] SRC_JR     = 2'd3;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [30:0] pc_low_inc;
    logic [31:0] redirect;
    logic        redirect_req;
    logic        irq_take;

    assign inst_addr = pc;

    // The kernel bit rides above a 31-bit incrementer so +4 can never set or clear it.
    assign pc_low_inc = pc[30:0] + 31'd4;
    assign pc4        = {pc[31], pc_low_inc};

    assign redirect_req = (pc_src != SRC_SEQ);

    // Interrupts are masked in kernel mode and while stalled; irq is level so it simply waits.
    assign irq_take = irq && !pc[31] && !stall;

    // Redirect target from ID; only jr may carry a different kernel bit.
    always_comb begin
        redirect = pc4;
        case (pc_src)
            SRC_BRANCH: redirect = {pc[31], branch_target[30:0]};
            SRC_JUMP:   redirect = {pc[31], pc4[30:28], jump_index, 2'b00};
            SRC_JR:     redirect = jr_target;
            default:    redirect = pc4;
        endcase
    end

    // PC, IF/ID and trap-return registers, with reset > exception > irq > stall > redirect > fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VEC;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            epc         <= 32'h0;
            epc_we      <= 1'b0;
        end else if (exception) begin
            // Resume after the faulting ID instruction.
            pc          <= EXC_VEC;
            epc         <= if_id_pc4;
            epc_we      <= 1'b1;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (irq_take) begin
            // A redirecting ID instruction completes; otherwise the squashed IF word is re-fetched.
            pc          <= IRQ_VEC;
            epc         <= redirect_req ? redirect : pc;
            epc_we      <= 1'b1;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            epc_we <= 1'b0;
            if (flush) begin
                if_id_inst  <= 32'h0;
                if_id_pc4   <= 32'h0;
                if_id_valid <= 1'b0;
            end
        end else if (redirect_req) begin
            pc          <= redirect;
            epc_we      <= 1'b0;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            pc     <= pc4;
            epc_we <= 1'b0;
            if (flush) begin
                if_id_inst  <= 32'h0;
                if_id_pc4   <= 32'h0;
                if_id_valid <= 1'b0;
            end else begin
                if_id_inst  <= inst_in;
                if_id_pc4   <= pc4;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        irq;
    logic        exception;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        epc_we;

    int n_cmp;
    int n_bad;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .irq           (irq),
        .exception     (exception),
        .inst_addr     (inst_addr),
        .inst_in       (inst_in),
        .if_id_inst    (if_id_inst),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .epc           (epc),
        .epc_we        (epc_we)
    );

    // ROM model: each word holds its own address.
    assign inst_in = inst_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [1:0]  src;
        logic [31:0] bt;
        logic [25:0] ji;
        logic [31:0] jr;
        logic        irq;
        logic        exc;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic        e_v;
        logic [31:0] e_epc;
        logic        e_we;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vec [NVEC];

    task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    initial begin
        int pulses;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'd0;
        branch_target = '0; jump_index = '0; jr_target = '0; irq = 1'b0; exception = 1'b0;

        //          rst   stl   fl    src    bt             ji            jr             irq   exc   pc             inst           pc4            v     epc            we
        vec[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h8000_0000, '0,            '0,            1'b0, '0,            1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 1'b1, '0,            1'b0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1'b1, '0,            1'b0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_00B0, '0,           '0,            1'b0, 1'b0, 32'h8000_00B0, '0,            '0,            1'b0, '0,            1'b0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_00B4, 1'b0, 1'b0, 32'h0000_00B4, '0,            '0,            1'b0, '0,            1'b0};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h0000_00B8, 32'h0000_00B4, 32'h0000_00B8, 1'b1, '0,            1'b0};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0100, 1'b0, 1'b0, 32'h0000_0100, '0,            '0,            1'b0, '0,            1'b0};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0004, '0,            '0,            1'b0, 32'h0000_0100, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1'b1, 32'h0000_0100, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1'b1, 32'h0000_0100, 1'b0};
        vec[10] = '{1'b0, 1'b1, 1'b1, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0008, '0,            '0,            1'b0, 32'h0000_0100, 1'b0};
        vec[11] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0200, 1'b0, 1'b0, 32'h0000_0200, '0,            '0,            1'b0, 32'h0000_0100, 1'b0};
        vec[12] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h0000_0204, 32'h0000_0200, 32'h0000_0204, 1'b1, 32'h0000_0100, 1'b0};
        vec[13] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h0000_0208, 32'h0000_0204, 32'h0000_0208, 1'b1, 32'h0000_0100, 1'b0};
        vec[14] = '{1'b0, 1'b1, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b1, 32'h8000_0008, '0,            '0,            1'b0, 32'h0000_0208, 1'b1};
        vec[15] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 1'b1, 32'h0000_0208, 1'b0};
        vec[16] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, '0,            '0,            1'b0, 32'h0000_0208, 1'b0};
        vec[17] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h0000_0014, 32'h0000_0010, 32'h0000_0014, 1'b1, 32'h0000_0208, 1'b0};
        vec[18] = '{1'b0, 1'b1, 1'b0, 2'd2, '0,            26'h3,        '0,            1'b0, 1'b0, 32'h0000_0014, 32'h0000_0010, 32'h0000_0014, 1'b1, 32'h0000_0208, 1'b0};
        vec[19] = '{1'b0, 1'b1, 1'b0, 2'd2, '0,            26'h3,        '0,            1'b0, 1'b0, 32'h0000_0014, 32'h0000_0010, 32'h0000_0014, 1'b1, 32'h0000_0208, 1'b0};
        vec[20] = '{1'b0, 1'b1, 1'b0, 2'd2, '0,            26'h3,        '0,            1'b0, 1'b0, 32'h0000_0014, 32'h0000_0010, 32'h0000_0014, 1'b1, 32'h0000_0208, 1'b0};
        vec[21] = '{1'b0, 1'b0, 1'b0, 2'd2, '0,            26'h3,        '0,            1'b0, 1'b0, 32'h0000_000C, '0,            '0,            1'b0, 32'h0000_0208, 1'b0};
        vec[22] = '{1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0300, '0,           '0,            1'b1, 1'b0, 32'h8000_0004, '0,            '0,            1'b0, 32'h0000_0300, 1'b1};
        vec[23] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h7FFF_FFFC, 1'b0, 1'b0, 32'h7FFF_FFFC, '0,            '0,            1'b0, 32'h0000_0300, 1'b0};
        vec[24] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h0000_0000, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0300, 1'b0};
        vec[25] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC, '0,            '0,            1'b0, 32'h0000_0300, 1'b0};
        vec[26] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFC, 32'h8000_0000, 1'b1, 32'h0000_0300, 1'b0};
        vec[27] = '{1'b0, 1'b0, 1'b1, 2'd0, '0,            '0,           '0,            1'b0, 1'b0, 32'h8000_0004, '0,            '0,            1'b0, 32'h0000_0300, 1'b0};
        vec[28] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040, '0,            '0,            1'b0, 32'h0000_0300, 1'b0};
        vec[29] = '{1'b0, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0004, '0,            '0,            1'b0, 32'h0000_0040, 1'b1};
        vec[30] = '{1'b1, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b0, 1'b1, 32'h8000_0000, '0,            '0,            1'b0, '0,            1'b0};
        vec[31] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040, '0,            '0,            1'b0, '0,            1'b0};
        vec[32] = '{1'b1, 1'b0, 1'b0, 2'd0, '0,            '0,           '0,            1'b1, 1'b0, 32'h8000_0000, '0,            '0,            1'b0, '0,            1'b0};
        vec[33] = '{1'b0, 1'b0, 1'b0, 2'd2, '0,            26'h3FF_FFFF, '0,            1'b0, 1'b0, 32'h8FFF_FFFC, '0,            '0,            1'b0, '0,            1'b0};
        vec[34] = '{1'b0, 1'b0, 1'b0, 2'd3, '0,            '0,           32'h0000_0020, 1'b0, 1'b0, 32'h0000_0020, '0,            '0,            1'b0, '0,            1'b0};
        vec[35] = '{1'b0, 1'b0, 1'b0, 2'd1, 32'hF000_0050, '0,           '0,            1'b0, 1'b0, 32'h7000_0050, '0,            '0,            1'b0, '0,            1'b0};
        vec[36] = '{1'b0, 1'b0, 1'b0, 2'd2, '0,            26'h10,       '0,            1'b0, 1'b0, 32'h7000_0040, '0,            '0,            1'b0, '0,            1'b0};

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            reset         = vec[i].rst;
            stall         = vec[i].stl;
            flush         = vec[i].fl;
            pc_src        = vec[i].src;
            branch_target = vec[i].bt;
            jump_index    = vec[i].ji;
            jr_target     = vec[i].jr;
            irq           = vec[i].irq;
            exception     = vec[i].exc;
            @(posedge clk);
            #1;
            check32("inst_addr",   i, inst_addr,   vec[i].e_pc);
            check32("if_id_inst",  i, if_id_inst,  vec[i].e_inst);
            check32("if_id_pc4",   i, if_id_pc4,   vec[i].e_pc4);
            check1 ("if_id_valid", i, if_id_valid, vec[i].e_v);
            check32("epc",         i, epc,         vec[i].e_epc);
            check1 ("epc_we",      i, epc_we,      vec[i].e_we);
        end

        // Held irq from user pc 7000_0040: exactly one strobe, then masked in kernel mode.
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'd0; exception = 1'b0;
        irq = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (epc_we) pulses++;
            if (c == 0) begin
                check32("irq_entry_pc",  100, inst_addr, 32'h8000_0004);
                check32("irq_entry_epc", 100, epc,       32'h7000_0040);
            end
        end
        check32("irq_pulse_count", 100, pulses, 32'd1);
        check32("irq_masked_pc",   100, inst_addr, 32'h8000_0014);
        @(negedge clk);
        irq = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
